rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter N, default 16, the register data width.
REQ-002 SHALL have parameter DEPTH, default 2, the per-requester queue depth (power of 2, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports alu_valid (input, 1), alu_ready (output, 1), alu_addr (input, 3) and alu_data (input, N): the ALU writeback request channel.
REQ-006 SHALL have ports mem_valid (input, 1), mem_ready (output, 1), mem_addr (input, 3) and mem_data (input, N): the load writeback request channel.
REQ-007 SHALL have ports rf_write_enable (output, 1), rf_write_addr (output, 3) and rf_write_data (output, N): drive the register file's single write port.
REQ-008 SHALL have ports rd_addr1 and rd_addr2, input, 3 bits each: decode-stage read addresses.
REQ-009 SHALL have ports rd_hazard1 and rd_hazard2, output, 1 bit each: a queued write exists to that address.
REQ-010 SHALL have ports fwd_hit1 and fwd_hit2 (output, 1 each) and fwd_data1 and fwd_data2 (output, N each): forwarding results.
REQ-011 SHALL have port busy_mask, output, 8 bits: bit i is set while any queued entry targets register i.

Function
REQ-012 SHALL give each channel a DEPTH-entry FIFO; a transfer occurs when valid and ready are both high at a rising edge.
REQ-013 SHALL drive each ready as (FIFO not full) OR (FIFO full AND that FIFO's head is granted this cycle).
REQ-014 SHALL grant at most one FIFO head per cycle; only one head non-empty: grant it; both non-empty: round-robin, starting with mem after reset.
REQ-015 SHALL dequeue the granted head at the edge and register it, so rf_write_enable is high for exactly one cycle after that edge with the head's addr and data.
REQ-016 SHALL give a minimum latency from accept edge to rf_write_enable high of 2 cycles (accept at E0, grant during E0..E1, write visible after E1).
REQ-017 SHALL keep rf_write_enable low on any cycle with no grant; rf_write_addr and rf_write_data hold their last values.
REQ-018 SHALL preserve per-channel write order; when both heads target the same address, SHALL grant mem first regardless of round-robin state and leave the pointer unchanged.
REQ-019 SHALL compute rd_hazardK combinationally as the OR over all valid entries in both FIFOs plus the registered output stage whose addr equals rd_addrK.
REQ-020 SHALL compute busy_mask as the same OR, decoded per register, including the registered output stage while rf_write_enable is high.
REQ-021 SHALL accept and grant in the same edge without corrupting occupancy, whether the FIFO is empty or full.
REQ-022 SHALL wrap the FIFO pointers modulo DEPTH; occupancy SHALL never exceed DEPTH or go below 0.

Reset
REQ-023 SHALL, while rst is low, force: FIFOs empty; round-robin to mem; rf_write_enable, rf_write_addr and rf_write_data 0; busy_mask 0; hazards and fwd_hit 0; alu_ready and mem_ready 0.
REQ-024 SHALL discard queued entries on reset mid-operation; no write is issued after rst is released until a new request is accepted.
REQ-025 SHALL raise alu_ready and mem_ready on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL use the macro RF_WRITE_ARBITER_FWD_EN to select forwarding.
REQ-027 SHALL, with RF_WRITE_ARBITER_FWD_EN defined, set fwd_hitK = rd_hazardK and drive fwd_dataK with the youngest matching data; priority: output stage < FIFO head < tail; mem entries newer than alu entries on a tie of position.
REQ-028 SHALL, without RF_WRITE_ARBITER_FWD_EN, keep the fwd ports present but tie fwd_hitK and fwd_dataK to 0; the forwarding logic is not compiled.

Structure
REQ-029 SHALL place in the shared processor package: the constant REG_ADDR_W = 3, the constant NUM_REGS = 8, and a typedef wb_req_t {addr, data}.
REQ-030 SHALL instantiate one sub-module, wb_fifo, twice (alu and mem); arbitration, output stage and hazard logic stay in the top level.

Verification
REQ-031 SHALL verify: single alu write addr 3, data 0x00AA, accepted at E0 -> rf_write_enable high after E1 only, addr 3, data 0x00AA; busy_mask 0x08 from E0 until the write completes.
REQ-032 SHALL verify: alu and mem both valid every cycle, distinct addresses 1 and 2 -> writes alternate mem, alu, mem, alu; each channel sustains 1 write per 2 cycles.
REQ-033 SHALL verify: both heads target addr 5, alu 0x1111 and mem 0x2222 -> mem written first, then alu; final write is 0x1111.
REQ-034 SHALL verify: 3 alu requests with mem idle -> alu_ready stays high (full-with-grant pass-through); writes appear back-to-back, in order.
REQ-035 SHALL verify: rd_addr1 = 4 with mem entry addr 4, data 0xBEEF queued -> rd_hazard1 = 1; with FWD_EN, fwd_hit1 = 1 and fwd_data1 = 0xBEEF; without FWD_EN, both 0.
REQ-036 SHALL verify: rst pulled low with 2 entries queued per FIFO -> all outputs 0 immediately; after release, no rf_write_enable pulse occurs.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared processor definitions for the register-file writeback arbiter.
// Requests carry a wide data field; each user keeps only its low N bits.
package rf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    RR_MEM = 1'b0,
    RR_ALU = 1'b1
  } rr_e;

endpackage

// File: rtl/rf_write_arbiter_wb_fifo.sv
// Small writeback request queue; exposes every slot oldest-first so the
// parent can scan queued addresses for hazards and forwarding.
module wb_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  wb_req_t               req_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output wb_req_t [DEPTH-1:0]   ord_o,
  output logic    [DEPTH-1:0]   ord_vld_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // A push into a full queue is legal only when the head leaves on the same edge.
  assign full_o  = (cnt_q == CNT_FULL);
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_ONE;
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_q] <= req_i;
        wr_q        <= wr_q + PTR_ONE;
      end
      if (do_pop) rd_q <= rd_q + PTR_ONE;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord_o[k]     = mem_q[rd_q + PW'(k)];
      ord_vld_o[k] = (cnt_q > (PW+1)'(k));
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Define RF_WRITE_ARBITER_FWD_EN to build the decode-stage forwarding network.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [N-1:0]          alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [N-1:0]          mem_data,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [N-1:0]          rf_write_data,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic                  rd_hazard1,
  output logic                  rd_hazard2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [N-1:0]          fwd_data1,
  output logic [N-1:0]          fwd_data2,
  output logic [NUM_REGS-1:0]   busy_mask
);

  wb_req_t                alu_req, mem_req;
  wb_req_t  [DEPTH-1:0]   alu_ord, mem_ord;
  logic     [DEPTH-1:0]   alu_vld, mem_vld;
  logic                   alu_full, mem_full;
  logic                   grant_alu, grant_mem;
  rr_e                    rr_q, rr_d;
  logic                   rdy_en_q;
  logic                   wen_q;
  logic [REG_ADDR_W-1:0]  waddr_q;
  logic [N-1:0]           wdata_q;
  logic                   unused_data;

  always_comb begin
    alu_req             = '0;
    alu_req.addr        = alu_addr;
    alu_req.data[N-1:0] = alu_data;
    mem_req             = '0;
    mem_req.addr        = mem_addr;
    mem_req.data[N-1:0] = mem_data;
  end

  // Ready stays low until the first edge after reset release.
  assign alu_ready = rdy_en_q && (!alu_full || grant_alu);
  assign mem_ready = rdy_en_q && (!mem_full || grant_mem);

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push_i    (alu_valid && alu_ready),
    .req_i     (alu_req),
    .pop_i     (grant_alu),
    .full_o    (alu_full),
    .ord_o     (alu_ord),
    .ord_vld_o (alu_vld)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push_i    (mem_valid && mem_ready),
    .req_i     (mem_req),
    .pop_i     (grant_mem),
    .full_o    (mem_full),
    .ord_o     (mem_ord),
    .ord_vld_o (mem_vld)
  );

  // Same-address heads always go mem-first so the load can never overwrite
  // a younger ALU result; the round-robin pointer only moves on real contention.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    rr_d      = rr_q;
    if (alu_vld[0] && mem_vld[0]) begin
      if (alu_ord[0].addr == mem_ord[0].addr) begin
        grant_mem = 1'b1;
      end else if (rr_q == RR_MEM) begin
        grant_mem = 1'b1;
        rr_d      = RR_ALU;
      end else begin
        grant_alu = 1'b1;
        rr_d      = RR_MEM;
      end
    end else if (alu_vld[0]) begin
      grant_alu = 1'b1;
    end else if (mem_vld[0]) begin
      grant_mem = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q     <= RR_MEM;
      rdy_en_q <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      rdy_en_q <= 1'b1;
      wen_q    <= grant_alu || grant_mem;
      if (grant_mem) begin
        waddr_q <= mem_ord[0].addr;
        wdata_q <= mem_ord[0].data[N-1:0];
      end else if (grant_alu) begin
        waddr_q <= alu_ord[0].addr;
        wdata_q <= alu_ord[0].data[N-1:0];
      end
    end
  end

  assign rf_write_enable = wen_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;

  always_comb begin
    busy_mask = '0;
    if (wen_q) busy_mask[waddr_q] = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (alu_vld[k]) busy_mask[alu_ord[k].addr] = 1'b1;
      if (mem_vld[k]) busy_mask[mem_ord[k].addr] = 1'b1;
    end
  end

  assign rd_hazard1 = busy_mask[rd_addr1];
  assign rd_hazard2 = busy_mask[rd_addr2];

`ifdef RF_WRITE_ARBITER_FWD_EN
  // Scan oldest to youngest so the last match wins; mem is newer on a position tie.
  always_comb begin
    fwd_data1 = '0;
    fwd_data2 = '0;
    if (wen_q && waddr_q == rd_addr1) fwd_data1 = wdata_q;
    if (wen_q && waddr_q == rd_addr2) fwd_data2 = wdata_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (alu_vld[k] && alu_ord[k].addr == rd_addr1) fwd_data1 = alu_ord[k].data[N-1:0];
      if (mem_vld[k] && mem_ord[k].addr == rd_addr1) fwd_data1 = mem_ord[k].data[N-1:0];
      if (alu_vld[k] && alu_ord[k].addr == rd_addr2) fwd_data2 = alu_ord[k].data[N-1:0];
      if (mem_vld[k] && mem_ord[k].addr == rd_addr2) fwd_data2 = mem_ord[k].data[N-1:0];
    end
  end
  assign fwd_hit1 = rd_hazard1;
  assign fwd_hit2 = rd_hazard2;
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

  assign unused_data = ^{alu_ord, mem_ord};

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a
// randomized run scored against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int N     = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [2:0]    alu_addr, mem_addr;
  logic [N-1:0]  alu_data, mem_data;
  logic          rf_write_enable;
  logic [2:0]    rf_write_addr;
  logic [N-1:0]  rf_write_data;
  logic [2:0]    rd_addr1, rd_addr2;
  logic          rd_hazard1, rd_hazard2;
  logic          fwd_hit1, fwd_hit2;
  logic [N-1:0]  fwd_data1, fwd_data2;
  logic [7:0]    busy_mask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rd_addr1        (rd_addr1),
    .rd_addr2        (rd_addr2),
    .rd_hazard1      (rd_hazard1),
    .rd_hazard2      (rd_hazard2),
    .fwd_hit1        (fwd_hit1),
    .fwd_hit2        (fwd_hit2),
    .fwd_data1       (fwd_data1),
    .fwd_data2       (fwd_data2),
    .busy_mask       (busy_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    rd_addr1  = '0;   rd_addr2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rf_write_enable, rf_write_addr, rf_write_data, busy_mask, rd_hazard1, rd_hazard2,
         fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, alu_ready, mem_ready} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got wen=%b addr=%0d data=%h busy=%h rdy=%b%b expected all 0",
               rf_write_enable, rf_write_addr, rf_write_data, busy_mask, alu_ready, mem_ready);
    end
    idle_inputs();
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL ready_before_edge: got %b%b expected 00", alu_ready, mem_ready);
    end
    tick();
    checks++;
    if ({alu_ready, mem_ready} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL ready_after_edge: got %b%b expected 11", alu_ready, mem_ready);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    tick();
    alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'h00AA;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_ready: got %b expected 1", alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++;
    if ({rf_write_enable, busy_mask} !== {1'b0, 8'h08}) begin
      failures++;
      $display("[TB] FAIL single_after_e0: got wen=%b busy=%h expected wen=0 busy=08", rf_write_enable, busy_mask);
    end
    tick();
    checks++;
    if ({rf_write_enable, rf_write_addr, rf_write_data, busy_mask} !== {1'b1, 3'd3, 16'h00AA, 8'h08}) begin
      failures++;
      $display("[TB] FAIL single_after_e1: got wen=%b addr=%0d data=%h busy=%h expected 1 3 00aa 08",
               rf_write_enable, rf_write_addr, rf_write_data, busy_mask);
    end
    tick();
    checks++;
    if ({rf_write_enable, rf_write_addr, rf_write_data, busy_mask} !== {1'b0, 3'd3, 16'h00AA, 8'h00}) begin
      failures++;
      $display("[TB] FAIL single_after_e2: got wen=%b addr=%0d data=%h busy=%h expected 0 3 00aa 00",
               rf_write_enable, rf_write_addr, rf_write_data, busy_mask);
    end
  endtask

  task automatic test_back_to_back();
    int wcount = 0, mcnt = 0, acnt = 0, asent = 0, msent = 0;
    bit expect_mem = 1'b1;
    logic ax, mx;
    logic [N-1:0] ev;
    do_reset();
    tick();
    alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'hA000;
    mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'hB000;
    for (int c = 0; c < 12; c++) begin
      #1;
      ax = alu_ready;
      mx = mem_ready;
      tick();
      if (ax) begin asent++; alu_data = 16'hA000 + 16'(asent); end
      if (mx) begin msent++; mem_data = 16'hB000 + 16'(msent); end
      if (rf_write_enable) begin
        wcount++;
        checks++;
        if (expect_mem) begin
          ev = 16'hB000 + 16'(mcnt);
          mcnt++;
          if ({rf_write_addr, rf_write_data} !== {3'd2, ev}) begin
            failures++;
            $display("[TB] FAIL rr_mem_turn: got addr=%0d data=%h expected addr=2 data=%h", rf_write_addr, rf_write_data, ev);
          end
        end else begin
          ev = 16'hA000 + 16'(acnt);
          acnt++;
          if ({rf_write_addr, rf_write_data} !== {3'd1, ev}) begin
            failures++;
            $display("[TB] FAIL rr_alu_turn: got addr=%0d data=%h expected addr=1 data=%h", rf_write_addr, rf_write_data, ev);
          end
        end
        expect_mem = !expect_mem;
      end
    end
    checks++;
    if (wcount !== 11 || mcnt !== 6 || acnt !== 5) begin
      failures++;
      $display("[TB] FAIL rr_throughput: got writes=%0d mem=%0d alu=%0d expected 11 6 5", wcount, mcnt, acnt);
    end
    idle_inputs();
  endtask

  task automatic test_same_addr();
    do_reset();
    tick();
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'h2222;
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 3'd5, 16'h2222}) begin
      failures++;
      $display("[TB] FAIL same_addr_first: got wen=%b addr=%0d data=%h expected 1 5 2222", rf_write_enable, rf_write_addr, rf_write_data);
    end
    tick();
    checks++;
    if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 3'd5, 16'h1111}) begin
      failures++;
      $display("[TB] FAIL same_addr_second: got wen=%b addr=%0d data=%h expected 1 5 1111", rf_write_enable, rf_write_addr, rf_write_data);
    end
    tick();
    checks++;
    if ({rf_write_enable, rf_write_data} !== {1'b0, 16'h1111}) begin
      failures++;
      $display("[TB] FAIL same_addr_final: got wen=%b data=%h expected 0 1111", rf_write_enable, rf_write_data);
    end
  endtask

  task automatic test_alu_burst();
    logic [N-1:0] wd[$];
    int wt[$];
    do_reset();
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        alu_valid = 1'b1; alu_addr = 3'(c + 1); alu_data = 16'h3000 + 16'(c);
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL burst_ready[%0d]: got %b expected 1", c, alu_ready);
        end
      end else begin
        alu_valid = 1'b0;
      end
      tick();
      if (rf_write_enable) begin
        wd.push_back(rf_write_data);
        wt.push_back(c);
      end
    end
    checks++;
    if (wd.size() !== 3) begin
      failures++;
      $display("[TB] FAIL burst_count: got %0d expected 3", wd.size());
    end
    for (int k = 0; k < wd.size(); k++) begin
      checks++;
      if (wd[k] !== 16'h3000 + 16'(k) || wt[k] !== k + 1) begin
        failures++;
        $display("[TB] FAIL burst_write[%0d]: got data=%h tick=%0d expected data=%h tick=%0d", k, wd[k], wt[k], 16'h3000 + 16'(k), k + 1);
      end
    end
  endtask

  task automatic test_hazard();
    do_reset();
    tick();
    rd_addr1 = 3'd4; rd_addr2 = 3'd5;
    mem_valid = 1'b1; mem_addr = 3'd4; mem_data = 16'hBEEF;
    tick();
    mem_valid = 1'b0;
    #1;
    checks++;
    if ({rd_hazard1, rd_hazard2, busy_mask} !== {1'b1, 1'b0, 8'h10}) begin
      failures++;
      $display("[TB] FAIL hazard_queued: got h1=%b h2=%b busy=%h expected 1 0 10", rd_hazard1, rd_hazard2, busy_mask);
    end
    checks++;
`ifdef RF_WRITE_ARBITER_FWD_EN
    if ({fwd_hit1, fwd_data1, fwd_hit2} !== {1'b1, 16'hBEEF, 1'b0}) begin
      failures++;
      $display("[TB] FAIL fwd_queued: got hit1=%b data1=%h hit2=%b expected 1 beef 0", fwd_hit1, fwd_data1, fwd_hit2);
    end
`else
    if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== '0) begin
      failures++;
      $display("[TB] FAIL fwd_disabled: got hit1=%b data1=%h expected 0 0", fwd_hit1, fwd_data1);
    end
`endif
    tick();
    checks++;
`ifdef RF_WRITE_ARBITER_FWD_EN
    if ({rd_hazard1, fwd_hit1, fwd_data1} !== {1'b1, 1'b1, 16'hBEEF}) begin
      failures++;
      $display("[TB] FAIL hazard_outstage: got h1=%b hit1=%b data1=%h expected 1 1 beef", rd_hazard1, fwd_hit1, fwd_data1);
    end
`else
    if ({rd_hazard1, fwd_hit1, fwd_data1} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL hazard_outstage: got h1=%b hit1=%b data1=%h expected 1 0 0", rd_hazard1, fwd_hit1, fwd_data1);
    end
`endif
    tick();
    checks++;
    if ({rd_hazard1, fwd_hit1, busy_mask} !== {1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL hazard_clear: got h1=%b hit1=%b busy=%h expected 0 0 00", rd_hazard1, fwd_hit1, busy_mask);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    rd_addr1 = 3'd1;
    alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h0001;
    mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'h0002;
    repeat (3) tick();
    checks++;
    if (busy_mask !== 8'h06) begin
      failures++;
      $display("[TB] FAIL midreset_prefill: got busy=%h expected 06", busy_mask);
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({rf_write_enable, rf_write_addr, rf_write_data, busy_mask, rd_hazard1, fwd_hit1,
         fwd_data1, alu_ready, mem_ready} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got wen=%b addr=%0d data=%h busy=%h h1=%b rdy=%b%b expected all 0",
               rf_write_enable, rf_write_addr, rf_write_data, busy_mask, rd_hazard1, alu_ready, mem_ready);
    end
    #3 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({rf_write_enable, busy_mask} !== 9'h000) begin
        failures++;
        $display("[TB] FAIL midreset_no_write[%0d]: got wen=%b busy=%h expected 0 00", c, rf_write_enable, busy_mask);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random(input int cycles);
    logic [2:0]   aq_a[$], mq_a[$];
    logic [N-1:0] aq_d[$], mq_d[$];
    bit           pref_mem, ga, gm, contested, e_ardy, e_mrdy;
    logic         e_wen;
    logic [2:0]   e_addr;
    logic [N-1:0] e_data;
    logic [7:0]   e_busy;
`ifdef RF_WRITE_ARBITER_FWD_EN
    logic [N-1:0] e_f1, e_f2;
`endif
    do_reset();
    tick();
    pref_mem = 1'b1;
    e_wen = 1'b0; e_addr = '0; e_data = '0;
    for (int c = 0; c < cycles; c++) begin
      checks++;
      if ({rf_write_enable, rf_write_addr, rf_write_data} !== {e_wen, e_addr, e_data}) begin
        failures++;
        $display("[TB] FAIL rand_write[%0d]: got wen=%b addr=%0d data=%h expected wen=%b addr=%0d data=%h",
                 c, rf_write_enable, rf_write_addr, rf_write_data, e_wen, e_addr, e_data);
      end
      alu_valid = ($urandom_range(0, 9) < 6);
      alu_addr  = 3'($urandom_range(0, 7));
      alu_data  = N'($urandom);
      mem_valid = ($urandom_range(0, 9) < 6);
      mem_addr  = 3'($urandom_range(0, 7));
      mem_data  = N'($urandom);
      rd_addr1  = 3'($urandom_range(0, 7));
      rd_addr2  = 3'($urandom_range(0, 7));
      #1;
      ga = 1'b0; gm = 1'b0;
      contested = (aq_a.size() > 0) && (mq_a.size() > 0) && (aq_a[0] != mq_a[0]);
      if (aq_a.size() > 0 && mq_a.size() > 0) begin
        if (!contested || pref_mem) gm = 1'b1;
        else ga = 1'b1;
      end else if (aq_a.size() > 0) begin
        ga = 1'b1;
      end else if (mq_a.size() > 0) begin
        gm = 1'b1;
      end
      e_ardy = (aq_a.size() < DEPTH) || ga;
      e_mrdy = (mq_a.size() < DEPTH) || gm;
      checks++;
      if ({alu_ready, mem_ready} !== {e_ardy, e_mrdy}) begin
        failures++;
        $display("[TB] FAIL rand_ready[%0d]: got %b%b expected %b%b", c, alu_ready, mem_ready, e_ardy, e_mrdy);
      end
      e_busy = '0;
      if (e_wen) e_busy[e_addr] = 1'b1;
      foreach (aq_a[k]) e_busy[aq_a[k]] = 1'b1;
      foreach (mq_a[k]) e_busy[mq_a[k]] = 1'b1;
      checks++;
      if ({busy_mask, rd_hazard1, rd_hazard2} !== {e_busy, e_busy[rd_addr1], e_busy[rd_addr2]}) begin
        failures++;
        $display("[TB] FAIL rand_busy[%0d]: got busy=%h h=%b%b expected busy=%h h=%b%b",
                 c, busy_mask, rd_hazard1, rd_hazard2, e_busy, e_busy[rd_addr1], e_busy[rd_addr2]);
      end
`ifdef RF_WRITE_ARBITER_FWD_EN
      e_f1 = '0; e_f2 = '0;
      if (e_wen && e_addr == rd_addr1) e_f1 = e_data;
      if (e_wen && e_addr == rd_addr2) e_f2 = e_data;
      for (int k = 0; k < DEPTH; k++) begin
        if (k < aq_a.size() && aq_a[k] == rd_addr1) e_f1 = aq_d[k];
        if (k < mq_a.size() && mq_a[k] == rd_addr1) e_f1 = mq_d[k];
        if (k < aq_a.size() && aq_a[k] == rd_addr2) e_f2 = aq_d[k];
        if (k < mq_a.size() && mq_a[k] == rd_addr2) e_f2 = mq_d[k];
      end
      checks++;
      if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {e_busy[rd_addr1], e_f1, e_busy[rd_addr2], e_f2}) begin
        failures++;
        $display("[TB] FAIL rand_fwd[%0d]: got %b %h %b %h expected %b %h %b %h", c, fwd_hit1, fwd_data1,
                 fwd_hit2, fwd_data2, e_busy[rd_addr1], e_f1, e_busy[rd_addr2], e_f2);
      end
`else
      checks++;
      if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== '0) begin
        failures++;
        $display("[TB] FAIL rand_fwd_off[%0d]: got %b %h %b %h expected 0", c, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
      end
`endif
      if (ga) begin
        e_wen = 1'b1; e_addr = aq_a.pop_front(); e_data = aq_d.pop_front();
        if (contested) pref_mem = 1'b1;
      end else if (gm) begin
        e_wen = 1'b1; e_addr = mq_a.pop_front(); e_data = mq_d.pop_front();
        if (contested) pref_mem = 1'b0;
      end else begin
        e_wen = 1'b0;
      end
      if (alu_valid && e_ardy) begin aq_a.push_back(alu_addr); aq_d.push_back(alu_data); end
      if (mem_valid && e_mrdy) begin mq_a.push_back(mem_addr); mq_d.push_back(mem_data); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_same_addr();
    test_alu_burst();
    test_hazard();
    test_reset_mid();
    test_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
